// File: rtl/mesh_node_interface.sv
// Mesh NoC resource-side interface: TX packetiser/injector and RX ejector.
// Optional statistics counters are built when NI_STATS_EN is defined.
module mesh_node_interface #(
  parameter int ROW_N        = 3,
  parameter int COL_M        = 3,
  parameter int ROW_CORD     = 0,
  parameter int COL_CORD     = 0,
  parameter int PCKT_DATA_W  = 8,
  parameter int FIFO_DEPTH_W = 3,
  localparam int RW = $clog2(ROW_N),
  localparam int CW = $clog2(COL_M),
  localparam int PW = PCKT_DATA_W + RW + CW
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   tx_valid_i,
  output logic                   tx_ready_o,
  input  logic [RW-1:0]          tx_row_i,
  input  logic [CW-1:0]          tx_col_i,
  input  logic [PCKT_DATA_W-1:0] tx_data_i,
  output logic [PW-1:0]          rsc_pckt_o,
  output logic                   rsc_wren_o,
  input  logic                   noc_full_i,
  input  logic                   noc_ovrflw_i,
  input  logic [PW-1:0]          noc_pckt_i,
  input  logic                   noc_wren_i,
  output logic                   rsc_full_o,
  output logic                   rsc_ovrflw_o,
  output logic                   rx_valid_o,
  input  logic                   rx_ready_i,
  output logic [PCKT_DATA_W-1:0] rx_data_o,
  output logic                   err_o,
  input  logic                   err_clr_i,
  output logic                   misroute_o,
  output logic [15:0]            tx_cnt_o,
  output logic [15:0]            rx_cnt_o,
  output logic [15:0]            drop_cnt_o
);

  localparam int FW    = FIFO_DEPTH_W;
  localparam int DEPTH = 1 << FW;
  localparam logic [FW:0]   FULL_C = (FW+1)'(DEPTH);
  localparam logic [RW-1:0] MY_ROW = RW'(ROW_CORD);
  localparam logic [CW-1:0] MY_COL = CW'(COL_CORD);

  typedef enum logic [1:0] {IDLE, SEND, ERR} tx_state_t;

  tx_state_t state, state_nxt;

  logic [PW-1:0] tx_mem [DEPTH];
  logic [FW-1:0] tx_wp, tx_rp;
  logic [FW:0]   tx_cnt, tx_cnt_nxt;
  logic          tx_push;

  assign tx_ready_o = (tx_cnt != FULL_C);
  assign tx_push    = tx_valid_i & tx_ready_o;
  assign rsc_pckt_o = tx_mem[tx_rp];
  assign rsc_wren_o = (state == SEND) & (tx_cnt != '0)
                    & !noc_full_i & !rst_i;
  assign tx_cnt_nxt = tx_cnt + (FW+1)'(tx_push) - (FW+1)'(rsc_wren_o);
  assign err_o      = (state == ERR);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tx_wp  <= '0;
      tx_rp  <= '0;
      tx_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) tx_mem[i] <= '0;
    end else begin
      if (tx_push) begin
        tx_mem[tx_wp] <= {tx_row_i, tx_col_i, tx_data_i};
        tx_wp         <= tx_wp + 1'b1;
      end
      if (rsc_wren_o) tx_rp <= tx_rp + 1'b1;
      tx_cnt <= tx_cnt_nxt;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  // State follows the post-update occupancy so injection can start next cycle
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (tx_cnt_nxt != '0) state_nxt = SEND;
      SEND:    if (tx_cnt_nxt == '0) state_nxt = IDLE;
      ERR:     if (err_clr_i)        state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (noc_ovrflw_i) state_nxt = ERR;
  end

  logic [PCKT_DATA_W-1:0] rx_mem [DEPTH];
  logic [FW-1:0] rx_wp, rx_rp;
  logic [FW:0]   rx_cnt;
  logic          rx_match, rx_hit, rx_pop, rx_push, rx_drop, rx_mis;

  assign rx_match = (noc_pckt_i[PW-1 -: RW] == MY_ROW)
                  & (noc_pckt_i[PCKT_DATA_W +: CW] == MY_COL);
  assign rx_hit     = noc_wren_i & rx_match;
  assign rx_mis     = noc_wren_i & !rx_match;
  assign rx_valid_o = (rx_cnt != '0);
  assign rx_pop     = rx_valid_o & rx_ready_i;
  assign rsc_full_o = (rx_cnt == FULL_C);
  assign rx_push    = rx_hit & (!rsc_full_o | rx_pop);
  assign rx_drop    = rx_hit & rsc_full_o & !rx_pop;
  assign rx_data_o  = rx_mem[rx_rp];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_wp        <= '0;
      rx_rp        <= '0;
      rx_cnt       <= '0;
      misroute_o   <= 1'b0;
      rsc_ovrflw_o <= 1'b0;
      for (int i = 0; i < DEPTH; i++) rx_mem[i] <= '0;
    end else begin
      if (rx_push) begin
        rx_mem[rx_wp] <= noc_pckt_i[PCKT_DATA_W-1:0];
        rx_wp         <= rx_wp + 1'b1;
      end
      if (rx_pop) rx_rp <= rx_rp + 1'b1;
      rx_cnt       <= rx_cnt + (FW+1)'(rx_push) - (FW+1)'(rx_pop);
      misroute_o   <= rx_mis;
      rsc_ovrflw_o <= rx_drop;
    end
  end

`ifdef NI_STATS_EN
  logic [15:0] tx_c, rx_c, drop_c;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tx_c   <= '0;
      rx_c   <= '0;
      drop_c <= '0;
    end else begin
      if (rsc_wren_o && tx_c != 16'hFFFF) tx_c <= tx_c + 1'b1;
      if (rx_push && rx_c != 16'hFFFF)    rx_c <= rx_c + 1'b1;
      if ((rx_mis | rx_drop) && drop_c != 16'hFFFF)
        drop_c <= drop_c + 1'b1;
    end
  end

  assign tx_cnt_o   = tx_c;
  assign rx_cnt_o   = rx_c;
  assign drop_cnt_o = drop_c;
`else
  assign tx_cnt_o   = '0;
  assign rx_cnt_o   = '0;
  assign drop_cnt_o = '0;
`endif

endmodule

// File: tb/tb_mesh_node_interface.sv
// Bench for mesh_node_interface at node (1,1) of a 3x3 mesh.
// A queue-based model predicts every output each cycle.
module tb_mesh_node_interface;

  logic        clk = 0;
  logic        rst_i;
  logic        tx_valid_i, tx_ready_o;
  logic [1:0]  tx_row_i, tx_col_i;
  logic [7:0]  tx_data_i;
  logic [11:0] rsc_pckt_o;
  logic        rsc_wren_o, noc_full_i, noc_ovrflw_i;
  logic [11:0] noc_pckt_i;
  logic        noc_wren_i, rsc_full_o, rsc_ovrflw_o;
  logic        rx_valid_o, rx_ready_i;
  logic [7:0]  rx_data_o;
  logic        err_o, err_clr_i, misroute_o;
  logic [15:0] tx_cnt_o, rx_cnt_o, drop_cnt_o;

  mesh_node_interface #(
    .ROW_N(3), .COL_M(3), .ROW_CORD(1), .COL_CORD(1),
    .PCKT_DATA_W(8), .FIFO_DEPTH_W(3)
  ) dut (
    .clk_i(clk), .rst_i(rst_i),
    .tx_valid_i(tx_valid_i), .tx_ready_o(tx_ready_o),
    .tx_row_i(tx_row_i), .tx_col_i(tx_col_i), .tx_data_i(tx_data_i),
    .rsc_pckt_o(rsc_pckt_o), .rsc_wren_o(rsc_wren_o),
    .noc_full_i(noc_full_i), .noc_ovrflw_i(noc_ovrflw_i),
    .noc_pckt_i(noc_pckt_i), .noc_wren_i(noc_wren_i),
    .rsc_full_o(rsc_full_o), .rsc_ovrflw_o(rsc_ovrflw_o),
    .rx_valid_o(rx_valid_o), .rx_ready_i(rx_ready_i),
    .rx_data_o(rx_data_o), .err_o(err_o), .err_clr_i(err_clr_i),
    .misroute_o(misroute_o), .tx_cnt_o(tx_cnt_o),
    .rx_cnt_o(rx_cnt_o), .drop_cnt_o(drop_cnt_o)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [11:0] txq[$];
  logic [7:0]  rxq[$];
  bit err_m, gap_m, mis_m, ovr_m;
  int tx_n, rx_n, drop_n;

  function automatic logic [11:0] pk(int r, int c, int d);
    return {2'(r), 2'(c), 8'(d)};
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit wren_exp();
    return !rst_i && !err_m && !gap_m && txq.size() > 0 && !noc_full_i;
  endfunction

  task automatic check_all();
    chk("tx_ready", tx_ready_o, txq.size() < 8);
    chk("rsc_wren", rsc_wren_o, wren_exp());
    if (txq.size() > 0) chk("tx_head", rsc_pckt_o, txq[0]);
    chk("err", err_o, err_m);
    chk("rx_valid", rx_valid_o, rxq.size() > 0);
    if (rxq.size() > 0) chk("rx_data", rx_data_o, rxq[0]);
    chk("rsc_full", rsc_full_o, rxq.size() == 8);
    chk("misroute", misroute_o, mis_m);
    chk("rsc_ovrflw", rsc_ovrflw_o, ovr_m);
`ifdef NI_STATS_EN
    chk("tx_cnt", tx_cnt_o, tx_n);
    chk("rx_cnt", rx_cnt_o, rx_n);
    chk("drop_cnt", drop_cnt_o, drop_n);
`else
    chk("tx_cnt", tx_cnt_o, 0);
    chk("rx_cnt", rx_cnt_o, 0);
    chk("drop_cnt", drop_cnt_o, 0);
`endif
  endtask

  // Applies the behavioural rules to the inputs held across the edge
  task automatic model_update();
    bit wr, acc, pop, hit;
    int rsz;
    if (rst_i) begin
      txq.delete(); rxq.delete();
      err_m = 0; gap_m = 0; mis_m = 0; ovr_m = 0;
      tx_n = 0; rx_n = 0; drop_n = 0;
      return;
    end
    wr  = wren_exp();
    acc = tx_valid_i && txq.size() < 8;
    pop = rxq.size() > 0 && rx_ready_i;
    hit = noc_wren_i && noc_pckt_i[11:8] == 4'b0101;
    rsz = rxq.size();
    if (wr) begin void'(txq.pop_front()); tx_n++; end
    if (acc) txq.push_back({tx_row_i, tx_col_i, tx_data_i});
    if (noc_ovrflw_i) begin err_m = 1; gap_m = 0; end
    else if (err_m && err_clr_i) begin err_m = 0; gap_m = 1; end
    else gap_m = 0;
    mis_m = noc_wren_i && !hit;
    ovr_m = 0;
    if (pop) void'(rxq.pop_front());
    if (hit) begin
      if (rsz == 8 && !pop) begin ovr_m = 1; drop_n++; end
      else begin rxq.push_back(noc_pckt_i[7:0]); rx_n++; end
    end
    if (mis_m) drop_n++;
  endtask

  task automatic tick();
    #1;
    check_all();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle_in();
    tx_valid_i = 0; noc_wren_i = 0; noc_ovrflw_i = 0; err_clr_i = 0;
  endtask

  initial begin
    rst_i = 1; idle_in();
    tx_row_i = 0; tx_col_i = 0; tx_data_i = 0;
    noc_full_i = 0; noc_pckt_i = 0; rx_ready_i = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_tx_ready", tx_ready_o, 1);
    chk("rst_pckt", rsc_pckt_o, 0);
    chk("rst_rx_data", rx_data_o, 0);
    check_all();
    rst_i = 0;
    tick();

    // loopback of a self-addressed packet
    tx_valid_i = 1; tx_row_i = 1; tx_col_i = 1; tx_data_i = 8'hA5;
    tick();
    idle_in();
    #1;
    chk("lb_wren", rsc_wren_o, 1);
    chk("lb_pckt", rsc_pckt_o, pk(1, 1, 8'hA5));
    tick();
    noc_pckt_i = pk(1, 1, 8'hA5); noc_wren_i = 1;
    tick();
    idle_in();
    #1;
    chk("lb_rx_valid", rx_valid_o, 1);
    chk("lb_rx_data", rx_data_o, 8'hA5);
    rx_ready_i = 1;
    tick();
    rx_ready_i = 0;

    // backpressure: fill TX while switch is full, then drain
    noc_full_i = 1;
    for (int i = 0; i < 8; i++) begin
      tx_valid_i = 1; tx_row_i = 2'(i % 3); tx_col_i = 2'(i % 2);
      tx_data_i = 8'(8'h10 + i);
      tick();
    end
    idle_in();
    #1;
    chk("bp_ready", tx_ready_o, 0);
    tick();
    noc_full_i = 0;
    repeat (10) tick();

    // RX overflow with consumer stalled
    for (int i = 0; i < 9; i++) begin
      noc_pckt_i = pk(1, 1, 8'h40 + i); noc_wren_i = 1;
      tick();
    end
    idle_in();
    #1;
    chk("ovf_pulse", rsc_ovrflw_o, 1);
    chk("ovf_head", rx_data_o, 8'h40);
    chk("ovf_full", rsc_full_o, 1);
    tick();
    rx_ready_i = 1;
    repeat (9) tick();
    rx_ready_i = 0;

    // misroute
    noc_pckt_i = pk(2, 0, 8'h3C); noc_wren_i = 1;
    tick();
    idle_in();
    #1;
    chk("mis_pulse", misroute_o, 1);
    chk("mis_valid", rx_valid_o, 0);
    tick();

    // error recovery with 3 queued packets
    noc_full_i = 1;
    for (int i = 0; i < 3; i++) begin
      tx_valid_i = 1; tx_row_i = 0; tx_col_i = 2; tx_data_i = 8'(8'hE0 + i);
      tick();
    end
    idle_in();
    noc_ovrflw_i = 1;
    tick();
    noc_ovrflw_i = 0; noc_full_i = 0;
    repeat (3) tick();
    #1;
    chk("err_flag", err_o, 1);
    err_clr_i = 1;
    tick();
    err_clr_i = 0;
    repeat (5) tick();

    // mid-transfer reset with both FIFOs partly full
    noc_full_i = 1;
    for (int i = 0; i < 4; i++) begin
      tx_valid_i = 1; tx_data_i = 8'(i);
      noc_pckt_i = pk(1, 1, 8'h70 + i); noc_wren_i = 1;
      tick();
    end
    idle_in();
    noc_full_i = 0; rst_i = 1;
    tick();
    rst_i = 0;
    #1;
    chk("mr_ready", tx_ready_o, 1);
    chk("mr_rx_valid", rx_valid_o, 0);
    chk("mr_wren", rsc_wren_o, 0);
    chk("mr_pckt", rsc_pckt_o, 0);
    tick();

    // randomized traffic
    for (int c = 0; c < 600; c++) begin
      tx_valid_i   = ($urandom_range(0, 2) != 0);
      tx_row_i     = 2'($urandom_range(0, 2));
      tx_col_i     = 2'($urandom_range(0, 2));
      tx_data_i    = 8'($urandom);
      noc_full_i   = ($urandom_range(0, 3) == 0);
      rx_ready_i   = ($urandom_range(0, 2) == 0);
      noc_wren_i   = ($urandom_range(0, 1) == 1);
      noc_pckt_i   = ($urandom_range(0, 4) != 0) ?
                     pk(1, 1, $urandom) : pk($urandom_range(0, 2), 0, $urandom);
      noc_ovrflw_i = ($urandom_range(0, 60) == 0);
      err_clr_i    = ($urandom_range(0, 8) == 0);
      rst_i        = ($urandom_range(0, 300) == 0);
      tick();
    end
    idle_in(); rst_i = 0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
